// File: rtl/mem_access_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_unit_if : pipeline request/result and byte-wide memory port   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       wdata_i;
  logic [1:0]        size_i;
  logic              sign_ext_i;
  logic              busy_o;
  logic              done_o;
  logic [31:0]       rdata_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_byte_o;
  logic              mem_grant_i;
  logic [7:0]        mem_byte_i;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, size_i, sign_ext_i, mem_grant_i, mem_byte_i,
    output busy_o, done_o, rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_byte_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, size_i, sign_ext_i, mem_grant_i, mem_byte_i,
    input  busy_o, done_o, rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_byte_o
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_unit : serializes loads/stores into little-endian byte reqs   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_LAST = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [1:0]        r_size;
  logic              r_sext;
  logic [1:0]        r_k;
  logic [1:0]        r_last_k;
  logic              r_cap_pend;
  logic [1:0]        r_cap_lane;
  logic [31:0]       r_asm;
  logic [31:0]       r_rdata;

  logic              w_accept;
  logic              w_grant;
  logic              w_grant_rd;
  logic [31:0]       w_asm;
  logic [31:0]       w_ext;

  assign w_grant    = (r_state == S_XFER) && bus.mem_grant_i;
  assign w_grant_rd = w_grant && !r_we;

  assign bus.busy_o  = (r_state != S_IDLE);
  assign bus.done_o  = (r_state == S_DONE);
  assign bus.rdata_o = r_rdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_accept        = 1'b0;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_byte_o  = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (bus.req_i) begin
          w_accept    = 1'b1;
          w_state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_we_o   = r_we;
        bus.mem_addr_o = r_addr + {{(ADDR_W-2){1'b0}}, r_k};
        bus.mem_byte_o = r_wdata[{r_k, 3'b000} +: 8];
        if (bus.mem_grant_i && (r_k == r_last_k)) begin
          w_state_nxt = r_we ? S_DONE : S_LAST;
        end
      end
      S_LAST: w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The byte returned for the previous granted read lands in its lane this cycle.
  always_comb begin
    w_asm = r_asm;
    if (r_cap_pend) begin
      w_asm[{r_cap_lane, 3'b000} +: 8] = bus.mem_byte_i;
    end
  end

  always_comb begin
    case (r_size)
      2'd0:    w_ext = {{24{r_sext & w_asm[7]}}, w_asm[7:0]};
      2'd1:    w_ext = {{16{r_sext & w_asm[15]}}, w_asm[15:0]};
      default: w_ext = w_asm;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
      r_size     <= 2'd0;
      r_sext     <= 1'b0;
      r_k        <= 2'd0;
      r_last_k   <= 2'd0;
      r_cap_pend <= 1'b0;
      r_cap_lane <= 2'd0;
      r_asm      <= 32'h0;
      r_rdata    <= 32'h0;
    end else begin
      r_cap_pend <= w_grant_rd;
      r_cap_lane <= r_k;
      r_asm      <= w_asm;
      if (w_accept) begin
        r_we     <= bus.we_i;
        r_addr   <= bus.addr_i;
        r_wdata  <= bus.wdata_i;
        r_size   <= bus.size_i;
        r_sext   <= bus.sign_ext_i;
        r_k      <= 2'd0;
        r_last_k <= (bus.size_i == 2'd0) ? 2'd0 :
                    (bus.size_i == 2'd1) ? 2'd1 : 2'd3;
        r_asm    <= 32'h0;
      end else if (w_grant && (r_k != r_last_k)) begin
        r_k <= r_k + 2'd1;
      end
      if (r_state == S_LAST) begin
        r_rdata <= w_ext;
      end
    end
  end

endmodule
`default_nettype wire
